// File: rtl/abs_multichannel_ctrl.sv
// rtl/abs_multichannel_ctrl.sv - N-channel ABS pressure-modulation controller with shared recovery pump
// Optional brake debounce: ABS_BRAKE_DEBOUNCE_EN
module abs_multichannel_ctrl #(
    parameter int N_CH        = 4,
    parameter int SPD_W       = 8,
    parameter int SLIP_PCT    = 20,
    parameter int TURN_PCT    = 10,
    parameter int RELEASE_CYC = 3,
    parameter int HOLD_CYC    = 2,
    parameter int REAPPLY_CYC = 2,
    parameter int PUMP_HOLD   = 4,
    parameter int DEB_CYCLES  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH*SPD_W-1:0] wheel_speed,
    input  logic [SPD_W-1:0]      vehicle_speed,
    input  logic [1:0]            direction,
    input  logic                  brake_signal,
    input  logic                  engine_status,
    output logic [N_CH-1:0]       inlet_close,
    output logic [N_CH-1:0]       outlet_open,
    output logic                  recovery_pump,
    output logic                  dir_fault
);
    localparam int MAXC_A = (RELEASE_CYC > HOLD_CYC) ? RELEASE_CYC : HOLD_CYC;
    localparam int MAXC   = (MAXC_A > REAPPLY_CYC) ? MAXC_A : REAPPLY_CYC;
    localparam int CW     = $clog2(MAXC) + 1;
    localparam int TW     = SPD_W + 7;
    localparam int PW     = $clog2(PUMP_HOLD + 1) + 1;

    if (N_CH < 1 || N_CH > 8 || SLIP_PCT + TURN_PCT > 100 || RELEASE_CYC < 1 ||
        HOLD_CYC < 1 || REAPPLY_CYC < 1 || PUMP_HOLD < 0 || DEB_CYCLES < 1) begin : g_param_check
        $error("abs_multichannel_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_NORMAL, S_ANTILOCK, S_RELEASE, S_HOLD, S_REAPPLY
    } state_t;

    state_t          state_q [N_CH];
    state_t          state_d [N_CH];
    logic [CW-1:0]   cnt_q   [N_CH];
    logic [CW-1:0]   cnt_d   [N_CH];
    logic            brk_q, brk_d;
    logic [N_CH-1:0] inlet_close_q, inlet_close_d;
    logic [N_CH-1:0] outlet_open_q, outlet_open_d;
    logic            recovery_pump_q, recovery_pump_d;
    logic [PW-1:0]   pump_tmr_q, pump_tmr_d;
    logic            dir_fault_q, dir_fault_d;
    logic [N_CH-1:0] slip_hi;
    logic [6:0]      thr;
    logic [TW-1:0]   thr_prod;
    logic            go;

`ifdef ABS_BRAKE_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES) + 1;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;

    always_comb begin
        brk_d     = brk_q;
        deb_cnt_d = '0;
        if (brake_signal != brk_q) begin
            if (deb_cnt_q >= DW'(DEB_CYCLES - 1)) brk_d = brake_signal;
            else deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) deb_cnt_q <= '0;
        else       deb_cnt_q <= deb_cnt_d;
    end
`else
    always_comb brk_d = brake_signal;
`endif

    assign go = brk_q && engine_status;

    // Threshold side (thr*vehicle) is shared; the diff side is per channel at full width.
    always_comb begin
        thr      = (direction == 2'b01 || direction == 2'b10) ? 7'(SLIP_PCT + TURN_PCT) : 7'(SLIP_PCT);
        thr_prod = TW'(thr) * TW'(vehicle_speed);
        slip_hi  = '0;
        for (int i = 0; i < N_CH; i++) begin
            slip_hi[i] = (vehicle_speed > wheel_speed[i*SPD_W +: SPD_W]) &&
                         ((TW'(vehicle_speed) - TW'(wheel_speed[i*SPD_W +: SPD_W])) * TW'(100) > thr_prod);
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = (cnt_q[i] == {CW{1'b1}}) ? cnt_q[i] : cnt_q[i] + 1'b1;
            if (!go) begin
                state_d[i] = S_NORMAL;
            end else begin
                case (state_q[i])
                    S_NORMAL:   state_d[i] = S_ANTILOCK;
                    S_ANTILOCK: if (slip_hi[i]) state_d[i] = S_RELEASE;
                    S_RELEASE:  if (cnt_q[i] >= CW'(RELEASE_CYC - 1) && !slip_hi[i]) state_d[i] = S_HOLD;
                    S_HOLD: begin
                        if (slip_hi[i])                            state_d[i] = S_RELEASE;
                        else if (cnt_q[i] >= CW'(HOLD_CYC - 1))    state_d[i] = S_REAPPLY;
                    end
                    S_REAPPLY: begin
                        if (slip_hi[i])                            state_d[i] = S_RELEASE;
                        else if (cnt_q[i] >= CW'(REAPPLY_CYC - 1)) state_d[i] = S_ANTILOCK;
                    end
                    default:    state_d[i] = S_NORMAL;
                endcase
            end
            if (state_d[i] != state_q[i] || state_d[i] == S_NORMAL) cnt_d[i] = '0;
        end
    end

    // Outputs decode the next state so valves move on the same edge as the FSM.
    always_comb begin
        inlet_close_d   = '0;
        outlet_open_d   = '0;
        for (int i = 0; i < N_CH; i++) begin
            inlet_close_d[i] = (state_d[i] == S_RELEASE) || (state_d[i] == S_HOLD);
            outlet_open_d[i] = (state_d[i] == S_RELEASE);
        end
        recovery_pump_d = (|inlet_close_d) || (pump_tmr_q != '0);
        if (|inlet_close_d)         pump_tmr_d = PW'(PUMP_HOLD);
        else if (pump_tmr_q != '0)  pump_tmr_d = pump_tmr_q - 1'b1;
        else                        pump_tmr_d = '0;
        dir_fault_d = (direction == 2'b11);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= S_NORMAL;
                cnt_q[i]   <= '0;
            end
            brk_q           <= 1'b0;
            inlet_close_q   <= '0;
            outlet_open_q   <= '0;
            recovery_pump_q <= 1'b0;
            pump_tmr_q      <= '0;
            dir_fault_q     <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            brk_q           <= brk_d;
            inlet_close_q   <= inlet_close_d;
            outlet_open_q   <= outlet_open_d;
            recovery_pump_q <= recovery_pump_d;
            pump_tmr_q      <= pump_tmr_d;
            dir_fault_q     <= dir_fault_d;
        end
    end

    assign inlet_close   = inlet_close_q;
    assign outlet_open   = outlet_open_q;
    assign recovery_pump = recovery_pump_q;
    assign dir_fault     = dir_fault_q;
endmodule
